pipeline_hazard_ctrl: RTL and testbench

- Central hazard and sequencing controller for the in-order pipeline.
- Detects load-use hazards between the decode stage and the load in the execute stage. Drives the 1-clock and 2-clock load-stall strobes and the flush strobe consumed by the fetch→decode pipeline register and the PC unit.
- Arbitrates between stall and redirect (taken branch/jump) requests. Sequences multi-cycle stalls and flushes with a small FSM.

---
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use hazard detection plus stall/flush sequencing FSM for the in-order pipeline.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int LOAD_LATENCY = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int REG_AW       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic              id_rs1_used_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_is_load_i,
    input  logic              ex_redirect_i,
    output logic              stall_from_ld_2clk_o,
    output logic              stall_from_ld_1clk_o,
    output logic              flush_o,
    output logic              pc_hold_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_flush_cnt_o,
`endif
    output logic [1:0]        ctrl_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD1  = 2'd1,
        FLUSH2 = 2'd2
    } state_t;

    state_t state, state_next;
    logic   hazard;
    logic   redirect_next_flush;

    // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
    assign hazard = ex_is_load_i && (ex_rd_i != '0) &&
                    ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                     (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

    assign redirect_next_flush = (FLUSH_CYCLES == 2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next           = IDLE;
        stall_from_ld_2clk_o = 1'b0;
        stall_from_ld_1clk_o = 1'b0;
        flush_o              = 1'b0;
        case (state)
            IDLE: begin
                if (ex_redirect_i) begin
                    flush_o    = 1'b1;
                    state_next = redirect_next_flush ? FLUSH2 : IDLE;
                end else if (hazard) begin
                    if (LOAD_LATENCY == 2) begin
                        stall_from_ld_2clk_o = 1'b1;
                        state_next           = HOLD1;
                    end else begin
                        stall_from_ld_1clk_o = 1'b1;
                    end
                end
            end
            HOLD1: begin
                // A redirect here kills the stalled instruction, so the stall is dropped.
                if (ex_redirect_i) begin
                    flush_o    = 1'b1;
                    state_next = redirect_next_flush ? FLUSH2 : IDLE;
                end else begin
                    stall_from_ld_1clk_o = 1'b1;
                end
            end
            FLUSH2: begin
                flush_o = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pc_hold_o    = stall_from_ld_2clk_o | stall_from_ld_1clk_o;
    assign ctrl_state_o = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pc_hold_o && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            // Count accepted redirects only, not the trailing FLUSH2 cycle.
            if (flush_o && (state != FLUSH2) && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: three parameterisations share one stimulus stream;
// the driver queues hand-computed expected outputs, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic       id_rs1_used = 1'b0;
    logic [4:0] id_rs2 = '0;
    logic       id_rs2_used = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       ex_is_load = 1'b0;
    logic       ex_redirect = 1'b0;

    logic       a_s2, a_s1, a_fl, a_ph;
    logic [1:0] a_st;
    logic       b_s2, b_s1, b_fl, b_ph;
    logic [1:0] b_st;
    logic       c_s2, c_s1, c_fl, c_ph;
    logic [1:0] c_st;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] a_pst, a_pfl, b_pst, b_pfl, c_pst, c_pfl;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // A: 2-cycle load stall, 2-cycle flush
    pipeline_hazard_ctrl #(.LOAD_LATENCY(2), .FLUSH_CYCLES(2), .REG_AW(5)) dut_a (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs1_used_i(id_rs1_used),
        .id_rs2_i(id_rs2), .id_rs2_used_i(id_rs2_used),
        .ex_rd_i(ex_rd), .ex_is_load_i(ex_is_load), .ex_redirect_i(ex_redirect),
        .stall_from_ld_2clk_o(a_s2), .stall_from_ld_1clk_o(a_s1),
        .flush_o(a_fl), .pc_hold_o(a_ph),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt_o(a_pst), .perf_flush_cnt_o(a_pfl),
`endif
        .ctrl_state_o(a_st)
    );

    // B: 2-cycle load stall, 1-cycle flush
    pipeline_hazard_ctrl #(.LOAD_LATENCY(2), .FLUSH_CYCLES(1), .REG_AW(5)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs1_used_i(id_rs1_used),
        .id_rs2_i(id_rs2), .id_rs2_used_i(id_rs2_used),
        .ex_rd_i(ex_rd), .ex_is_load_i(ex_is_load), .ex_redirect_i(ex_redirect),
        .stall_from_ld_2clk_o(b_s2), .stall_from_ld_1clk_o(b_s1),
        .flush_o(b_fl), .pc_hold_o(b_ph),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt_o(b_pst), .perf_flush_cnt_o(b_pfl),
`endif
        .ctrl_state_o(b_st)
    );

    // C: 1-cycle load stall, 1-cycle flush
    pipeline_hazard_ctrl #(.LOAD_LATENCY(1), .FLUSH_CYCLES(1), .REG_AW(5)) dut_c (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs1_used_i(id_rs1_used),
        .id_rs2_i(id_rs2), .id_rs2_used_i(id_rs2_used),
        .ex_rd_i(ex_rd), .ex_is_load_i(ex_is_load), .ex_redirect_i(ex_redirect),
        .stall_from_ld_2clk_o(c_s2), .stall_from_ld_1clk_o(c_s1),
        .flush_o(c_fl), .pc_hold_o(c_ph),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt_o(c_pst), .perf_flush_cnt_o(c_pfl),
`endif
        .ctrl_state_o(c_st)
    );

    typedef struct {
        logic       chk;
        int         id;
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] c;
    } exp_t;

    exp_t sb[$];
    int   step_id = 0;

    // Packs expected {stall2, stall1, flush, pc_hold, state}.
    function automatic logic [5:0] mk(input logic s2, input logic s1, input logic fl,
                                      input logic [1:0] st);
        return {s2, s1, fl, s2 | s1, st};
    endfunction

    localparam logic [5:0] Z = 6'b000000;

    task automatic step(input logic r,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic ld, input logic rdr,
                        input logic [5:0] ea, input logic [5:0] eb, input logic [5:0] ec,
                        input logic ck);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        id_rs1 = rs1; id_rs1_used = u1;
        id_rs2 = rs2; id_rs2_used = u2;
        ex_rd = rd; ex_is_load = ld; ex_redirect = rdr;
        e.chk = ck; e.id = step_id; e.a = ea; e.b = eb; e.c = ec;
        sb.push_back(e);
        step_id++;
    endtask

    task automatic idle(input logic [5:0] ea, input logic [5:0] eb, input logic [5:0] ec);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, ea, eb, ec, 1'b1);
    endtask

    task automatic hz(input logic rdr, input logic [5:0] ea, input logic [5:0] eb,
                      input logic [5:0] ec);
        step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, rdr, ea, eb, ec, 1'b1);
    endtask

    task automatic redir(input logic [5:0] ea, input logic [5:0] eb, input logic [5:0] ec);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, ea, eb, ec, 1'b1);
    endtask

    task automatic rst_cycle();
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, Z, Z, Z, 1'b0);
    endtask

    // Monitor: every cycle the DUTs present outputs; pop and compare.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [5:0] act;
            e = sb.pop_front();
            if (e.chk) begin
                act = {a_s2, a_s1, a_fl, a_ph, a_st};
                total_cnt++;
                if (act === e.a) pass_cnt++;
                else $display("FAIL step%0d dut_a outs: got %b want %b", e.id, act, e.a);
                act = {b_s2, b_s1, b_fl, b_ph, b_st};
                total_cnt++;
                if (act === e.b) pass_cnt++;
                else $display("FAIL step%0d dut_b outs: got %b want %b", e.id, act, e.b);
                act = {c_s2, c_s1, c_fl, c_ph, c_st};
                total_cnt++;
                if (act === e.c) pass_cnt++;
                else $display("FAIL step%0d dut_c outs: got %b want %b", e.id, act, e.c);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        total_cnt++;
        if (sb.size() == 0) pass_cnt++;
        else $display("FAIL drain: got %0d pending want 0", sb.size());
    endtask

    initial begin
        rst_cycle();
        rst_cycle();
        idle(Z, Z, Z);                                                 // reset state
        // rs1 load-use: A/B 2-cycle stall, C 1-cycle stall
        hz(1'b0, mk(1,0,0,0), mk(1,0,0,0), mk(0,1,0,0));
        idle(mk(0,1,0,1), mk(0,1,0,1), Z);
        idle(Z, Z, Z);
        // x0 destination never hazards; unused rs2 never hazards
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, Z, Z, Z, 1'b1);
        step(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, Z, Z, Z, 1'b1);
        // rs2 match
        step(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0,
             mk(1,0,0,0), mk(1,0,0,0), mk(0,1,0,0), 1'b1);
        idle(mk(0,1,0,1), mk(0,1,0,1), Z);
        // hazard + redirect together: redirect wins; FLUSH2 ignores inputs
        hz(1'b1, mk(0,0,1,0), mk(0,0,1,0), mk(0,0,1,0));
        hz(1'b1, mk(0,0,1,2), mk(0,0,1,0), mk(0,0,1,0));
        idle(Z, Z, Z);
        // redirect arriving in HOLD1
        hz(1'b0, mk(1,0,0,0), mk(1,0,0,0), mk(0,1,0,0));
        redir(mk(0,0,1,1), mk(0,0,1,1), mk(0,0,1,0));
        idle(mk(0,0,1,2), Z, Z);
        idle(Z, Z, Z);
        // reset during HOLD1, then a held hazard restarts a full stall
        hz(1'b0, mk(1,0,0,0), mk(1,0,0,0), mk(0,1,0,0));
        rst_cycle();
        idle(Z, Z, Z);
        hz(1'b0, mk(1,0,0,0), mk(1,0,0,0), mk(0,1,0,0));
        hz(1'b0, mk(0,1,0,1), mk(0,1,0,1), mk(0,1,0,0));
        idle(Z, Z, Z);
        // reset during FLUSH2
        redir(mk(0,0,1,0), mk(0,0,1,0), mk(0,0,1,0));
        rst_cycle();
        idle(Z, Z, Z);
`ifdef HAZARD_PERF_CNT_EN
        for (int i = 0; i < 3; i++) begin
            hz(1'b0, mk(1,0,0,0), mk(1,0,0,0), mk(0,1,0,0));
            idle(mk(0,1,0,1), mk(0,1,0,1), Z);
        end
        redir(mk(0,0,1,0), mk(0,0,1,0), mk(0,0,1,0));
        idle(mk(0,0,1,2), Z, Z);
        idle(Z, Z, Z);
        drain();
        total_cnt++;
        if (a_pst == 32'd6) pass_cnt++;
        else $display("FAIL perf_stall: got %0d want 6", a_pst);
        total_cnt++;
        if (a_pfl == 32'd1) pass_cnt++;
        else $display("FAIL perf_flush: got %0d want 1", a_pfl);
        total_cnt++;
        if (c_pst == 32'd3) pass_cnt++;
        else $display("FAIL perf_stall_c: got %0d want 3", c_pst);
        @(negedge clk);
        force dut_a.perf_stall_q = 32'hFFFF_FFFF;
        #1;
        release dut_a.perf_stall_q;
        hz(1'b0, mk(1,0,0,0), mk(1,0,0,0), mk(0,1,0,0));
        idle(mk(0,1,0,1), mk(0,1,0,1), Z);
        @(negedge clk);
        total_cnt++;
        if (a_pst == 32'hFFFF_FFFF) pass_cnt++;
        else $display("FAIL perf_sat: got %h want ffffffff", a_pst);
        idle(Z, Z, Z);
`endif
        drain();
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
